axi_slv_rd_mo: RTL
==================

AXI_SLV_RD_MO -- requirements
Module: axi_slv_rd_mo

Interface
REQ-001 Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
REQ-002 Parameter ID_W, 4, ARID width.
REQ-003 Parameter ADDR_W, 16, address width.
REQ-004 Parameter DATA_W, 32, data width, SHALL be >= ID_W+ADDR_W.
REQ-005 Parameter LEN_W, 8, ARLEN width.
REQ-006 Parameter DEPTH, 4, outstanding AR capacity, power of two >= 2.
REQ-007 Parameter LAT, 2, fetch cycles per beat, range 1..15.
REQ-008 Parameter BASE, 'h0, decode region start; parameter SPAN, 'h8000, decode region size in bytes.
REQ-009 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-010 arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/LEN_W/3/2  AR payload; arvalid  in  1; arready  out  1.
REQ-011 rid  out  ID_W; rdata  out  DATA_W; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.

Function
REQ-012 arready SHALL be 1 exactly when the AR FIFO holds fewer than DEPTH entries, and SHALL not depend on arvalid or rready.
REQ-013 An AR handshake SHALL push {id, addr, len, size, burst, decerr}, where decerr = addr outside [BASE, BASE+SPAN).
REQ-014 Transactions SHALL be returned strictly in acceptance order; rid SHALL equal the head entry's id on every beat.
REQ-015 The read FSM SHALL have states IDLE, FETCH and RESP: IDLE->FETCH on FIFO non-empty; FETCH->RESP after LAT cycles; RESP->FETCH on a non-last beat handshake; RESP->IDLE/FETCH on a last-beat handshake (pop, empty/non-empty).
REQ-016 A decerr transaction SHALL skip FETCH (0-cycle latency), return arlen+1 beats with rresp=DECERR and rdata=0.
REQ-017 Payload beats: rdata = {zeros, id, beat_addr}; rresp = OKAY, except SLVERR on the last beat when id is all ones.
REQ-018 beat_addr for beat 0 SHALL be araddr; subsequent beats SHALL follow the burst type with bytes = 1<<size.
REQ-019 FIXED: beat_addr constant.
REQ-020 INCR: beat_addr += bytes, modulo 2^ADDR_W.
REQ-021 WRAP: boundary = floor(addr/(bytes*(len+1)))*(bytes*(len+1)); on reaching boundary+bytes*(len+1) the address SHALL return to boundary.
REQ-022 WRAP with len not in {1,3,7,15} and burst=2'b11 SHALL be treated as INCR with rresp=SLVERR on every beat.
REQ-023 rlast SHALL be 1 only while rvalid=1 on beat index == len; no-handshake beats SHALL not advance the index.
REQ-024 rvalid SHALL be held with stable rid/rdata/rresp/rlast until rready.
REQ-025 A push and a last-beat pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-026 Minimum AR-to-first-rvalid latency SHALL be LAT+1 cycles for a non-decerr transaction accepted into an empty, idle block.

Reset
REQ-027 On rst_n low: FIFO empty, FSM IDLE, arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=OKAY, beat counters 0.
REQ-028 Reset mid-burst SHALL discard all outstanding transactions with no further R beats.

Structure
REQ-029 Burst encodings (FIXED=0, INCR=1, WRAP=2) and resp encodings (OKAY=0, SLVERR=2, DECERR=3) SHALL come from shared package axi_pkg.
REQ-030 Next-address calculation SHALL be the combinational sub-module axi_burst_addr (inputs addr, start, size, len, burst; output next_addr).

Verification
REQ-031 ARID=3, addr 'h0010, len=3, size=2, INCR, rready=1 -> 4 beats with addr 'h10/'h14/'h18/'h1C, rlast on beat 4, first rvalid 3 cycles after AR.
REQ-032 WRAP, addr 'h0038, len=3, size=2 -> addresses 'h38, 'h3C, 'h30, 'h34.
REQ-033 Six back-to-back ARs, rready=0 -> arready drops after 4 accepts; returns to 1 the cycle after the first last-beat handshake; IDs returned in order.
REQ-034 addr 'h9000, len=1 -> 2 beats with DECERR, rdata=0, rvalid the cycle after the AR; ARID='hF INCR len=0 -> single beat with SLVERR and rlast=1.
REQ-035 Random rready stalls during a 16-beat FIXED burst -> payload stable while stalled, all beats at the same address.
REQ-036 Assert rst_n low during beat 2 of 4 with 2 transactions queued -> rvalid=0 and arready=1 after reset; no stale beats.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/resp encodings and read FSM states
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_RESP} rd_state_t;

  // Only 2/4/8/16-beat WRAP bursts have a power-of-two wrap window.
  function automatic logic wrap_len_ok(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - combinational next beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] start,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  import axi_pkg::*;

  logic [ADDR_W-1:0] bytes, incr, total, mask;

  always_comb begin
    bytes     = ADDR_W'(1) << size;
    incr      = addr + bytes;
    total     = bytes * (ADDR_W'(len) + ADDR_W'(1));
    mask      = total - ADDR_W'(1);
    next_addr = incr;
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP && wrap_len_ok(32'(len)))
      next_addr = (start & ~mask) | (incr & mask);
  end

endmodule

// File: rtl/axi_rd_ar_fifo.sv
// rtl/axi_rd_ar_fifo.sv - AR command queue with head and next-head peek
module axi_rd_ar_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [W-1:0]             next_head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  // Entry that becomes head after a pop; with one entry it is whatever is being pushed now.
  assign next_head = (count == CW'(1)) ? push_data : mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/axi_slv_rd_mo.sv
// rtl/axi_slv_rd_mo.sv - AXI read slave with multiple outstanding in-order ARs
module axi_slv_rd_mo #(
  parameter int          ID_W   = 4,
  parameter int          ADDR_W = 16,
  parameter int          DATA_W = 32,
  parameter int          LEN_W  = 8,
  parameter int          DEPTH  = 4,
  parameter int          LAT    = 2,
  parameter logic [31:0] BASE   = 32'h0,
  parameter logic [31:0] SPAN   = 32'h8000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  import axi_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              decerr;
  } ar_ent_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  ar_ent_t           push_ent, head, nxt, start_ent;
  logic [CNT_W-1:0]  count;
  logic              push, pop, last_hs, start_go, step_go;
  rd_state_t         state;
  logic [3:0]        lat_cnt;
  logic [LEN_W-1:0]  beat_idx;
  logic [ADDR_W-1:0] beat_addr, next_addr;
  beat_t             b_start, b_step, b_fetch;

  function automatic beat_t mk_beat(input ar_ent_t e, input logic [ADDR_W-1:0] a,
                                    input logic [LEN_W-1:0] idx);
    beat_t b;
    logic  bad_burst;
    bad_burst = (e.burst == BURST_WRAP && !wrap_len_ok(32'(e.len))) || (e.burst == 2'b11);
    b.last = (idx == e.len);
    b.data = e.decerr ? '0 : DATA_W'({e.id, a});
    if (e.decerr)
      b.resp = RESP_DECERR;
    else if (bad_burst || (b.last && (&e.id)))
      b.resp = RESP_SLVERR;
    else
      b.resp = RESP_OKAY;
    return b;
  endfunction

  assign arready  = (count < CNT_W'(DEPTH));
  assign push     = arvalid && arready;
  // Offset compare covers both ends of the region with one unsigned test.
  assign push_ent = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst,
                      decerr: ((32'(araddr) - BASE) >= SPAN)};

  axi_rd_ar_fifo #(.W($bits(ar_ent_t)), .DEPTH(DEPTH)) u_ar_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head),
    .next_head (nxt),
    .count     (count)
  );

  axi_burst_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_burst_addr (
    .addr      (beat_addr),
    .start     (head.addr),
    .size      (head.size),
    .len       (head.len),
    .burst     (head.burst),
    .next_addr (next_addr)
  );

  assign last_hs   = (state == ST_RESP) && rready && rlast;
  assign pop       = last_hs;
  assign step_go   = (state == ST_RESP) && rready && !rlast;
  assign start_ent = (state == ST_RESP) ? nxt : head;
  assign start_go  = ((state == ST_IDLE) && (count != '0)) ||
                     (last_hs && ((count > CNT_W'(1)) || push));
  assign b_start   = mk_beat(start_ent, start_ent.addr, '0);
  assign b_step    = mk_beat(head, next_addr, beat_idx + LEN_W'(1));
  assign b_fetch   = mk_beat(head, beat_addr, beat_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      beat_idx  <= '0;
      beat_addr <= '0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else if (start_go) begin
      beat_idx  <= '0;
      beat_addr <= start_ent.addr;
      lat_cnt   <= '0;
      rid       <= start_ent.id;
      if (start_ent.decerr) begin
        state                 <= ST_RESP;
        rvalid                <= 1'b1;
        {rdata, rresp, rlast} <= b_start;
      end else begin
        state  <= ST_FETCH;
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end else if (step_go) begin
      beat_idx  <= beat_idx + LEN_W'(1);
      beat_addr <= next_addr;
      lat_cnt   <= '0;
      if (head.decerr) begin
        {rdata, rresp, rlast} <= b_step;
      end else begin
        state  <= ST_FETCH;
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end else if (last_hs) begin
      state  <= ST_IDLE;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end else if (state == ST_FETCH) begin
      if (lat_cnt == 4'(LAT - 1)) begin
        state                 <= ST_RESP;
        rvalid                <= 1'b1;
        {rdata, rresp, rlast} <= b_fetch;
      end else begin
        lat_cnt <= lat_cnt + 4'd1;
      end
    end
  end

endmodule
